iir_biquad_tdm: RTL
===================

IIR_BIQUAD_TDM -- requirements
Module: iir_biquad_tdm

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning signed sample width of x and y.
REQ-002 SHALL have parameter COEF_W, default 16, meaning signed coefficient width.
REQ-003 SHALL have parameter FRAC_W, default 14, meaning coefficient fractional bits (1.0 = 2^FRAC_W).
REQ-004 SHALL have parameter N_CH, default 4, meaning channel count; CH_W = max(1, clog2(N_CH)).
REQ-005 SHALL have port clk, input, 1, meaning the single clock. All logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning reset. Reset is asynchronous and active-low.
REQ-007 SHALL have ports in_valid (in, 1), in_ready (out, 1), in_ch (in, CH_W) and x (in, DATA_W, signed), meaning the input sample handshake.
REQ-008 SHALL have ports out_valid (out, 1), out_ready (in, 1), out_ch (out, CH_W) and y (out, DATA_W, signed), meaning the output sample handshake.
REQ-009 SHALL have ports coef_we (in, 1), coef_addr (in, 3) and coef_data (in, COEF_W, signed), meaning the coefficient write port.
REQ-010 SHALL have port ovf, output, 1, meaning the sticky overflow flag.

Function
REQ-011 SHALL compute Direct Form I per channel: y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2].
- Coefficients are shared by all channels.
- Each channel holds its own x1, x2, y1, y2.
REQ-012 SHALL implement FSM states IDLE, MAC, HOLD:
- IDLE -> MAC on in_valid && in_ready.
- MAC runs exactly 5 cycles, one product per cycle, in order b0, b1, b2, a1, a2, then goes to HOLD.
- HOLD -> IDLE on out_ready.
REQ-013 SHALL drive in_ready = 1 only in IDLE. A sample is accepted in cycle T and latched together with in_ch.
REQ-014 SHALL assert out_valid at cycle T+6 with y and out_ch, and hold y, out_ch and out_valid stable until out_ready is sampled high.
REQ-015 SHALL, in the cycle out_ready is sampled high in HOLD, update that channel's state: x2<=x1, x1<=x, y2<=y1, y1<=y (the final output value).
- Other channels SHALL remain untouched.
REQ-016 SHALL use a signed accumulator of DATA_W+COEF_W+3 bits.
- Result = (acc + 2^(FRAC_W-1)) >>> FRAC_W, arithmetic shift (round half up).
- The result is then reduced to DATA_W per REQ-024/025.
REQ-017 SHALL write coefficients only in IDLE. coef_addr values: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2.
- Writes outside IDLE, or with coef_addr 5..7, SHALL be ignored.
REQ-018 SHALL handle a coefficient write and a sample accept in the same IDLE cycle as follows: the write takes effect and the accepted sample uses the new coefficient.
REQ-019 SHALL treat in_ch >= N_CH as accepted but discarded: no computation, no out_valid, return to IDLE next cycle.

Reset
REQ-020 SHALL, while rst=0, set the FSM to IDLE and drive in_ready=1, out_valid=0, y=0, out_ch=0, ovf=0.
REQ-021 SHALL reset coefficients to b0 = 2^FRAC_W and b1 = b2 = a1 = a2 = 0, giving passthrough.
- All channel x1, x2, y1, y2 SHALL reset to 0.
REQ-022 SHALL, on reset asserted during MAC or HOLD, abandon the in-flight sample with no state update and no out_valid.

Configuration
REQ-023 SHALL use macro IIR_SAT_EN.
REQ-024 SHALL, with IIR_SAT_EN defined, clamp the rounded result to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- ovf SHALL set on any clamp and stay set until reset.
REQ-025 SHALL, with IIR_SAT_EN undefined, truncate to the low DATA_W bits (wrap) and tie ovf to 0.

Structure
REQ-026 SHALL place the FSM state typedef, the coefficient index constants (B0..A2) and the accumulator width function in shared package iir_pkg.
REQ-027 SHALL implement rounding and saturation/wrap in sub-module iir_round_sat, instantiated once.

Verification
REQ-028 SHALL cover passthrough after reset:
- ch0 x=1000 -> y=1000, out_ch=0, out_valid exactly 6 cycles after accept.
REQ-029 SHALL cover delay and channel isolation with b0=0, b1=16384:
- ch0 x=100 then x=200 -> y=0 then y=100.
- ch1 x=7 interleaved -> y=0, and ch0 results are unchanged.
REQ-030 SHALL cover feedback with b0=16384, a1=-8192:
- ch2 impulse 1000, 0, 0 -> y = 1000, 500, 250.
REQ-031 SHALL cover saturation with IIR_SAT_EN defined and b0=32767:
- x=30000 -> y=32767, ovf=1.
- Without the macro, the same stimulus -> wrapped value, ovf=0.
REQ-032 SHALL cover backpressure:
- out_ready low for 3 cycles in HOLD -> y and out_valid held, in_ready=0, coef_we ignored.
- out_ready high -> IDLE next cycle.
REQ-033 SHALL cover reset mid-MAC:
- rst=0 at cycle T+3 -> no out_valid, and the next sample on that channel behaves as if from reset.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared types and constants for the time-multiplexed biquad.
// FSM state, coefficient slot indices and accumulator sizing.
package iir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [2:0] B0 = 3'd0;
    localparam logic [2:0] B1 = 3'd1;
    localparam logic [2:0] B2 = 3'd2;
    localparam logic [2:0] A1 = 3'd3;
    localparam logic [2:0] A2 = 3'd4;

    function automatic int acc_w(input int data_w, input int coef_w);
        return data_w + coef_w + 3;
    endfunction

endpackage

// File: rtl/iir_round_sat.sv
// Round-half-up and reduce the accumulator to the sample width.
// IIR_SAT_EN selects clamping with clip report; otherwise wrap.
module iir_round_sat #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 35,
    parameter int FRAC_W = 14
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] y,
    output logic                     clip
);

    localparam logic signed [ACC_W-1:0] HALF =
        ACC_W'(64'sd1 <<< (FRAC_W - 1));

    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] rnd;

    assign sum = acc + HALF;
    assign rnd = sum >>> FRAC_W;

`ifdef IIR_SAT_EN
    localparam logic signed [ACC_W-1:0] Y_MAX =
        ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] Y_MIN =
        ACC_W'(-(64'sd1 <<< (DATA_W - 1)));

    always_comb begin
        clip = 1'b0;
        y    = rnd[DATA_W-1:0];
        if (rnd > Y_MAX) begin
            clip = 1'b1;
            y    = Y_MAX[DATA_W-1:0];
        end else if (rnd < Y_MIN) begin
            clip = 1'b1;
            y    = Y_MIN[DATA_W-1:0];
        end
    end
`else
    logic unused_hi;

    assign unused_hi = ^rnd[ACC_W-1:DATA_W];
    assign y         = rnd[DATA_W-1:0];
    assign clip      = 1'b0;
`endif

endmodule

// File: rtl/iir_biquad_tdm.sv
// Direct Form I biquad shared by N_CH channels, one MAC per cycle.
// Optional output saturation and sticky ovf via IIR_SAT_EN.
module iir_biquad_tdm
    import iir_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int FRAC_W = 14,
    parameter int N_CH   = 4,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CH_W-1:0]          in_ch,
    input  logic signed [DATA_W-1:0] x,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH_W-1:0]          out_ch,
    output logic signed [DATA_W-1:0] y,
    input  logic                     coef_we,
    input  logic [2:0]               coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     ovf
);

    localparam int ACC_W = acc_w(DATA_W, COEF_W);
    localparam int PRD_W = DATA_W + COEF_W;
    localparam logic signed [COEF_W-1:0] ONE =
        COEF_W'(64'sd1 <<< FRAC_W);

    state_t state, state_nx;

    logic [2:0]               step;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] x_q;
    logic [CH_W-1:0]          ch_q;

    logic signed [COEF_W-1:0] coef [5];
    logic signed [DATA_W-1:0] x1 [N_CH];
    logic signed [DATA_W-1:0] x2 [N_CH];
    logic signed [DATA_W-1:0] y1 [N_CH];
    logic signed [DATA_W-1:0] y2 [N_CH];

    logic                     ch_ok;
    logic                     accept;
    logic signed [COEF_W-1:0] c_sel;
    logic signed [DATA_W-1:0] d_sel;
    logic signed [PRD_W-1:0]  prod;
    logic signed [ACC_W-1:0]  term;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [DATA_W-1:0] y_r;
    logic                     clip;

    assign ch_ok     = 32'(in_ch) < 32'(N_CH);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;

    always_comb begin
        c_sel = coef[0];
        d_sel = x_q;
        case (step)
            B1: begin
                c_sel = coef[1];
                d_sel = x1[ch_q];
            end
            B2: begin
                c_sel = coef[2];
                d_sel = x2[ch_q];
            end
            A1: begin
                c_sel = coef[3];
                d_sel = y1[ch_q];
            end
            A2: begin
                c_sel = coef[4];
                d_sel = y2[ch_q];
            end
            default: ;
        endcase
    end

    assign prod = PRD_W'(c_sel) * PRD_W'(d_sel);
    assign term = ACC_W'(prod);
    // Feedback taps enter with negative sign.
    assign acc_sum = (step == A1 || step == A2) ? acc - term
                                                : acc + term;

    iir_round_sat #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W),
        .FRAC_W(FRAC_W)
    ) u_round_sat (
        .acc (acc_sum),
        .y   (y_r),
        .clip(clip)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept && ch_ok) state_nx = MAC;
            MAC:  if (step == A2) state_nx = HOLD;
            HOLD: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            step    <= B0;
            acc     <= '0;
            x_q     <= '0;
            ch_q    <= '0;
            y       <= '0;
            out_ch  <= '0;
            ovf     <= 1'b0;
            coef[0] <= ONE;
            for (int i = 1; i < 5; i++) coef[i] <= '0;
            for (int c = 0; c < N_CH; c++) begin
                x1[c] <= '0;
                x2[c] <= '0;
                y1[c] <= '0;
                y2[c] <= '0;
            end
        end else begin
            state <= state_nx;
            if (coef_we && state == IDLE) begin
                case (coef_addr)
                    B0: coef[0] <= coef_data;
                    B1: coef[1] <= coef_data;
                    B2: coef[2] <= coef_data;
                    A1: coef[3] <= coef_data;
                    A2: coef[4] <= coef_data;
                    default: ;
                endcase
            end
            unique case (state)
                IDLE: begin
                    if (accept && ch_ok) begin
                        x_q  <= x;
                        ch_q <= in_ch;
                        step <= B0;
                        acc  <= '0;
                    end
                end
                MAC: begin
                    acc  <= acc_sum;
                    step <= step + 3'd1;
                    if (step == A2) begin
                        y      <= y_r;
                        out_ch <= ch_q;
                        ovf    <= ovf | clip;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        x2[ch_q] <= x1[ch_q];
                        x1[ch_q] <= x_q;
                        y2[ch_q] <= y1[ch_q];
                        y1[ch_q] <= y;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
